imem_loader: RTL

Boot-time program loader that sits directly upstream of the pipelined MIPS core. It accepts a byte stream over a valid/ready handshake, packs it big-endian into 32-bit instruction words, and writes them sequentially into instruction memory from word 0. It holds the core in reset until the load completes, then releases it.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/byte_packer.sv | 43 ++++
 rtl/imem_loader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared core constants and program-loader state encoding
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [2:0] LD_IDLE  = 3'd0;
  localparam logic [2:0] LD_RECV  = 3'd1;
  localparam logic [2:0] LD_WRITE = 3'd2;
  localparam logic [2:0] LD_CHECK = 3'd3;
  localparam logic [2:0] LD_DONE  = 3'd4;
  localparam logic [2:0] LD_ERROR = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = LD_IDLE,
    ST_RECV  = LD_RECV,
    ST_WRITE = LD_WRITE,
    ST_CHECK = LD_CHECK,
    ST_DONE  = LD_DONE,
    ST_ERROR = LD_ERROR
  } ld_state_e;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - big-endian byte-to-instruction-word shift packer
module byte_packer
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               shift_en_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_full_o
);

  logic [1:0]         cnt_q, cnt_d;
  logic [INSTR_W-1:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (shift_en_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[INSTR_W-9:0], byte_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Pulses alongside the 4th byte so the packed word is in shift_q on the following cycle.
  assign word_full_o = shift_en_i && !clear_i && (cnt_q == 2'd3);
  assign word_o      = shift_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader into instruction memory (option: LOADER_CHECKSUM_EN)
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W:0]    word_count,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_rst,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_e ST_FIN = ST_CHECK;
`else
  localparam ld_state_e ST_FIN = ST_DONE;
`endif

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   wc_q, wc_d, idx_q, idx_d, idx_inc, wc_clamped;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              byte_ready_q, imem_we_q, cpu_rst_q, busy_q, done_q;
  logic              start_acc, accept, data_acc, word_full;

  assign start_acc  = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
  assign accept     = byte_valid && byte_ready_q;
  assign data_acc   = accept && (state_q == ST_RECV);
  assign idx_inc    = idx_q + 1'b1;
  assign wc_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       err_q;
`endif

  byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (start_acc),
    .shift_en_i  (data_acc),
    .byte_i      (byte_data),
    .word_o      (imem_wdata),
    .word_full_o (word_full)
  );

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    if (data_acc) csum_d = csum_q + byte_data;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          wc_d    = wc_clamped;
          idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = (wc_clamped == '0) ? ST_FIN : ST_RECV;
        end
      end
      ST_RECV: begin
        if (word_full) begin
          state_d = ST_WRITE;
          addr_d  = idx_q[ADDR_W-1:0];
        end
      end
      ST_WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == wc_q) ? ST_FIN : ST_RECV;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) state_d = (byte_data == csum_q) ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Every output flag is a registered decode of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wc_q         <= '0;
      idx_q        <= '0;
      addr_q       <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wc_q         <= wc_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      byte_ready_q <= (state_d == ST_RECV) || (state_d == ST_CHECK);
      imem_we_q    <= (state_d == ST_WRITE);
      cpu_rst_q    <= (state_d != ST_DONE);
      busy_q       <= (state_d == ST_RECV) || (state_d == ST_WRITE) || (state_d == ST_CHECK);
      done_q       <= (state_d == ST_DONE);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err_q  <= (state_d == ST_ERROR);
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = addr_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
